// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller.
//   state_t      : controller FSM states (IDLE / REQ / DONE / ERR)
//   WORD_W       : data/address width of the memory bus
//   ALIGN_MASK   : address bits that must be zero for an aligned halfword access
//   is_unaligned : helper that applies ALIGN_MASK to a byte address
package mem_stage_ctrl_pkg;

    localparam int unsigned WORD_W = 16;

    localparam logic [WORD_W-1:0] ALIGN_MASK = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    function automatic logic is_unaligned(input logic [WORD_W-1:0] addr);
        return |(addr & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the memory-stage controller and the data memory.
//   mem_req   : request strobe (controller -> memory), held until mem_ack
//   mem_we    : 1 = write, valid with mem_req
//   mem_addr  : byte address, valid with mem_req
//   mem_wdata : store data, valid with mem_req
//   mem_ack   : one-cycle completion pulse (memory -> controller)
//   mem_rdata : load data, valid with mem_ack
// Modports: master = controller side, slave = memory side.
interface mem_stage_ctrl_if;
    import mem_stage_ctrl_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_stage_ctrl_dff_pipe.sv
// Pipeline register primitive.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears q
//   stall : hold enable, q keeps its value while high
//   flush : synchronous clear, takes priority over stall
//   d / q : data in / registered data out (W bits)
module dff_pipe #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller between the EX/MEM and MEM/WB pipeline registers.
// Issues one request per load/store to a variable-latency data memory, stalls
// the pipeline until the access completes, holds load data for MEM/WB, and
// raises a sticky error on unaligned accesses or memory timeouts.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   valid_mem        : EX/MEM holds a live instruction
//   MEMREAD_mem      : instruction is a load
//   MEMWRITE_mem     : instruction is a store
//   alu_out_mem      : byte address
//   wrData_mem       : store data
//   bus              : data-memory bus (master side)
//   stall_mem        : freeze PC, IF/ID, ID/EX and EX/MEM
//   memData_out_mem  : load data presented to MEM/WB
//   err_mem          : sticky error (unaligned access or timeout)
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_mem,
    input  logic                 MEMREAD_mem,
    input  logic                 MEMWRITE_mem,
    input  logic [WORD_W-1:0]    alu_out_mem,
    input  logic [WORD_W-1:0]    wrData_mem,
    mem_stage_ctrl_if.master     bus,
    output logic                 stall_mem,
    output logic [WORD_W-1:0]    memData_out_mem,
    output logic                 err_mem
);

    // The counter must reach TIMEOUT-1 and never wrap.
    generate
        if (TIMEOUT < 2 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
            $error("mem_stage_ctrl: TIMEOUT must be >= 2 and < 2**CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              op;
    logic              unaligned;
    logic              take_req;
    logic              rd_capture;
    logic              req_q;
    logic [0:0]        we_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;

    assign op        = valid_mem & (MEMREAD_mem | MEMWRITE_mem);
    assign unaligned = is_unaligned(alu_out_mem);

    // Launch a request only from IDLE with an aligned address.
    assign take_req   = (state == ST_IDLE) & op & ~unaligned;
    // mem_we is the latched store flag, so a load is the request with mem_we low.
    assign rd_capture = (state == ST_REQ) & bus.mem_ack & ~we_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_mem = 1'b0;
        err_mem   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (op) begin
                    if (unaligned) begin
                        state_nxt = ST_ERR;
                    end else begin
                        state_nxt = ST_REQ;
                        stall_mem = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                stall_mem = 1'b1;
                // An ack on the last permitted cycle still completes the access.
                if (bus.mem_ack) begin
                    state_nxt = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_DONE: begin
                // The held op is the one that just completed; let it advance.
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                stall_mem = 1'b1;
                err_mem   = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (take_req) begin
            cnt <= '0;
        end else if (state == ST_REQ) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered request: high for every cycle the FSM sits in REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= 1'b0;
        end else begin
            req_q <= (state_nxt == ST_REQ);
        end
    end

    dff_pipe #(.W(1)) u_we (
        .clk   (clk),
        .rst   (rst),
        .stall (~take_req),
        .flush (1'b0),
        .d     (MEMWRITE_mem),
        .q     (we_q)
    );

    dff_pipe #(.W(WORD_W)) u_addr (
        .clk   (clk),
        .rst   (rst),
        .stall (~take_req),
        .flush (1'b0),
        .d     (alu_out_mem),
        .q     (addr_q)
    );

    dff_pipe #(.W(WORD_W)) u_wdata (
        .clk   (clk),
        .rst   (rst),
        .stall (~take_req),
        .flush (1'b0),
        .d     (wrData_mem),
        .q     (wdata_q)
    );

    dff_pipe #(.W(WORD_W)) u_rdata (
        .clk   (clk),
        .rst   (rst),
        .stall (~rd_capture),
        .flush (1'b0),
        .d     (bus.mem_rdata),
        .q     (memData_out_mem)
    );

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q[0];
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule
